// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: an Avalon-MM read master that fetches the
// system ID (word 0) and build timestamp (word 1), latches both and compares
// them against the values the software build expects. Each read attempt has
// a cycle budget and a bounded number of retries.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h6065_4836,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [16:0] TimeoutLim = 17'(TIMEOUT_CYCLES);
    localparam logic [7:0]  RetryLim   = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StIdle,
        StIdReq,
        StIdWait,
        StTsReq,
        StTsWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic        auto_q, auto_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        tmo_err_q, tmo_err_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic        tmo_hit;
    logic        tmo_fire;
    logic        enter_check;
    state_e      retry_state;

    // Budget is spent once the count of cycles in this attempt reaches the limit.
    assign tmo_hit = ({1'b0, tmo_cnt_q} + 17'd1) == TimeoutLim;

    // Next-state, capture, retry and comparison logic.
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_d     = retry_q;
        auto_d      = 1'b0;
        id_ok_d     = id_ok_q;
        ts_ok_d     = ts_ok_q;
        tmo_err_d   = tmo_err_q;
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;
        tmo_fire    = 1'b0;
        enter_check = 1'b0;
        retry_state = StIdReq;

        if (state_q inside {StIdReq, StIdWait, StTsReq, StTsWait}) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start || auto_q) begin
                    enter_check = 1'b1;
                end
            end
            StIdReq, StTsReq: begin
                retry_state = state_q;
                if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end else if (!avm_waitrequest) begin
                    state_d = (state_q == StIdReq) ? StIdWait : StTsWait;
                end
            end
            StIdWait: begin
                retry_state = StIdReq;
                // A response on the final budgeted cycle still counts.
                if (avm_readdatavalid) begin
                    id_value_d = avm_readdata;
                    state_d    = StTsReq;
                    retry_d    = 8'd0;
                    tmo_cnt_d  = 16'd0;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end
            end
            StTsWait: begin
                retry_state = StTsReq;
                if (avm_readdatavalid) begin
                    ts_value_d = avm_readdata;
                    state_d    = StDone;
                    id_ok_d    = (id_value_q == EXPECTED_ID);
                    ts_ok_d    = (avm_readdata == EXPECTED_TS);
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end
            end
            StDone: begin
                if (start) begin
                    enter_check = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (tmo_fire) begin
            if (retry_q < RetryLim) begin
                retry_d   = retry_q + 8'd1;
                tmo_cnt_d = 16'd0;
                state_d   = retry_state;
            end else begin
                tmo_err_d = 1'b1;
                id_ok_d   = 1'b0;
                ts_ok_d   = 1'b0;
                state_d   = StDone;
            end
        end

        if (enter_check) begin
            state_d   = StIdReq;
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
            tmo_err_d = 1'b0;
            retry_d   = 8'd0;
            tmo_cnt_d = 16'd0;
        end
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            tmo_cnt_q  <= 16'd0;
            retry_q    <= 8'd0;
            auto_q     <= AUTO_START;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            tmo_err_q  <= 1'b0;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            retry_q    <= retry_d;
            auto_q     <= auto_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            tmo_err_q  <= tmo_err_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    // Bus and status outputs decode directly from the state register.
    always_comb begin
        avm_read    = (state_q == StIdReq) || (state_q == StTsReq);
        avm_address = (state_q == StTsReq);
        busy        = state_q inside {StIdReq, StIdWait, StTsReq, StTsWait};
        done        = (state_q == StDone);
        id_ok       = id_ok_q;
        ts_ok       = ts_ok_q;
        timeout_err = tmo_err_q;
        id_value    = id_value_q;
        ts_value    = ts_value_q;
    end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID slave: after reset (or on request) it reads word 0 (system ID) and word 1 (build timestamp), latches both, and compares them against expected values.
- Flags match/mismatch and bus timeouts so the boot controller and status LEDs can refuse to run software built for a different hardware image.

Parameters:
- EXPECTED_ID, 32'h0000_0000, system ID the software build expects.
- EXPECTED_TS, 32'h6065_4836, build timestamp the software build expects.
- TIMEOUT_CYCLES, 255, cycles allowed per read attempt, counted from the first avm_read assertion until readdatavalid; range 1..65535.
- MAX_RETRIES, 2, extra attempts per word after a timeout before giving up.
- AUTO_START, 1, if 1, starts a check automatically on the first cycle after reset release.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a check when the block is not busy
- avm_address  out  1  word address: 0 = ID, 1 = timestamp
- avm_read  out  1  Avalon read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data valid
- busy  out  1  check in progress
- done  out  1  level; check finished, held until the next accepted start
- id_ok  out  1  captured ID == EXPECTED_ID
- ts_ok  out  1  captured timestamp == EXPECTED_TS
- timeout_err  out  1  a word exhausted its retries
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp

Behaviour:
- Clocking and reset: one clock domain. When reset_n is low at a rising edge, all outputs go to 0, the FSM goes to IDLE, and the timeout counter and retry counter clear. Reset mid-transaction drops avm_read on that edge, with no handshake completion.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- IDLE
  - Go to ID_REQ on start=1, or on the first cycle after reset when AUTO_START=1.
  - On entry to ID_REQ, clear done, id_ok, ts_ok, timeout_err and the retry count; set busy=1.
- ID_REQ / TS_REQ
  - avm_read=1; avm_address is 0 in ID_REQ and 1 in TS_REQ.
  - address and read are held stable while avm_waitrequest=1.
  - The request is accepted on an edge where avm_read=1 and avm_waitrequest=0; go to the matching WAIT state with avm_read=0 on the next cycle.
- ID_WAIT / TS_WAIT
  - avm_read=0.
  - On the first cycle with avm_readdatavalid=1, capture avm_readdata into id_value or ts_value.
  - Then advance ID_WAIT->TS_REQ (retry count cleared) or TS_WAIT->DONE.
  - Minimum total: 2 cycles REQ->WAIT->next when waitrequest=0 and readdatavalid arrives the cycle after acceptance.
- avm_readdatavalid is sampled only in WAIT states; in every other state it is ignored, so stray responses are discarded.
- Timeout
  - A 16-bit counter resets on entry to each REQ state and increments every cycle in REQ/WAIT.
  - When it equals TIMEOUT_CYCLES without capture: if retries < MAX_RETRIES, increment retries and re-enter the same REQ state; otherwise set timeout_err=1 and go to DONE.
  - If readdatavalid arrives on the same cycle the counter hits the limit, the capture wins and there is no timeout.
- Comparison
  - id_ok and ts_ok are registered on entry to DONE from the captured values.
  - Both are forced to 0 when timeout_err=1.
- DONE
  - done=1, busy=0.
  - start=1 restarts the check (same entry actions as IDLE->ID_REQ).
- start while busy=1 is ignored.
- id_value and ts_value hold their last captured values across checks; they are cleared only by reset.

Test Plan:
- Slave model returns 0x0000_0000 at address 0 and 0x6065_4836 at address 1, with waitrequest=0 and readdatavalid 1 cycle after accept; AUTO_START=1, release reset -> done=1, id_ok=1, ts_ok=1, timeout_err=0 within 6 cycles of reset release; exactly 2 accepted reads, at address 0 then 1.
- Slave returns timestamp 0x6065_4837 -> id_ok=1, ts_ok=0, ts_value=0x6065_4837, timeout_err=0.
- waitrequest held high for 5 cycles on the ID read -> avm_read and avm_address=0 stable all 5 cycles; the check completes correctly 5 cycles later than the first scenario.
- Slave never asserts readdatavalid on address 1, TIMEOUT_CYCLES=10, MAX_RETRIES=2 -> 3 read attempts at address 1, then timeout_err=1, id_ok=0, ts_ok=0, done=1.
- start pulsed while busy, then again in DONE -> the first pulse has no effect; the second clears done and flags and repeats the full read sequence.
- reset_n driven low while in TS_WAIT, with a stray readdatavalid after release (AUTO_START=0) -> all outputs 0, FSM in IDLE, stray data not captured.
